// File: rtl/serial_feed_sched.sv
// serial_feed_sched: shares one to_serial serializer between NUM_REQ vector producers.
// Define SERIAL_FEED_SCHED_RR_EN for round-robin arbitration; default is fixed priority (lowest index).
module serial_feed_sched #(
   parameter int BW      = 16,
   parameter int CYCS    = 4,
   parameter int VEC_LEN = 27,
   parameter int NUM_REQ = 4,
   parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_vld,
   input  logic [NUM_REQ*VEC_LEN*BW-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_rdy,
   output logic                          ser_vld_in,
   output logic [VEC_LEN*BW-1:0]         ser_in,
   input  logic                          ser_vld_out,
   output logic [IDW-1:0]                owner_id,
   output logic                          owner_vld,
   output logic                          err_align
);

   localparam int VW = VEC_LEN * BW;
   localparam int CW = $clog2(CYCS);
   localparam int MW = $clog2(CYCS + 1);
   localparam logic [CW-1:0] SLOT_LAST = CW'(CYCS - 1);
   localparam logic [MW-1:0] MASK_INIT = MW'(CYCS);

   logic [CW-1:0]  slot;
   logic [CW-1:0]  own_cnt;
   logic [MW-1:0]  mask_cnt;
   logic [IDW-1:0] pend_id;
   logic [IDW-1:0] pick;
   logic [IDW-1:0] cand;
   logic           pick_vld;
   logic           slot_free;
   logic           xfer;
   logic [VW-1:0]  sel_data;

   // Handshake: a vector moves on a rising edge where req_vld[i] & req_rdy[i];
   // req_rdy is only raised while the slot is free, and req_vld must not wait on req_rdy.
   assign slot_free = (slot == '0);

`ifdef SERIAL_FEED_SCHED_RR_EN
   logic [IDW-1:0] rr_ptr;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr <= IDW'(NUM_REQ - 1);
      end else if (xfer) begin
         rr_ptr <= pick;
      end
   end

   // Scan from the highest offset down so the nearest requester after rr_ptr wins.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      cand     = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = IDW'((int'(rr_ptr) + 1 + i) % NUM_REQ);
         if (req_vld[cand]) begin
            pick     = cand;
            pick_vld = 1'b1;
         end
      end
   end
`else
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      cand     = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = IDW'(i);
         if (req_vld[cand]) begin
            pick     = cand;
            pick_vld = 1'b1;
         end
      end
   end
`endif

   // Grant is held off while reset is asserted so nothing is offered before the first live edge.
   assign xfer = pick_vld & slot_free & reset_n;

   always_comb begin
      req_rdy = '0;
      if (xfer) begin
         req_rdy[pick] = 1'b1;
      end
   end

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick == IDW'(i)) begin
            sel_data = req_data[i*VW +: VW];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         slot       <= '0;
         ser_vld_in <= 1'b0;
         ser_in     <= '0;
         pend_id    <= '0;
      end else if (xfer) begin
         slot       <= SLOT_LAST;
         ser_vld_in <= 1'b1;
         ser_in     <= sel_data;
         pend_id    <= pick;
      end else begin
         ser_vld_in <= 1'b0;
         if (slot != '0) begin
            slot <= slot - 1'b1;
         end
      end
   end

   // Ownership mirrors the serializer: it loads on the edge where ser_vld_in is high.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         owner_id  <= '0;
         owner_vld <= 1'b0;
         own_cnt   <= '0;
      end else if (ser_vld_in) begin
         owner_id  <= pend_id;
         owner_vld <= 1'b1;
         own_cnt   <= SLOT_LAST;
      end else if (own_cnt != '0) begin
         own_cnt <= own_cnt - 1'b1;
      end else begin
         owner_vld <= 1'b0;
      end
   end

   // The serializer is not reset, so its tail may still be draining for CYCS edges after release.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_align <= 1'b0;
         mask_cnt  <= MASK_INIT;
      end else if (mask_cnt != '0) begin
         mask_cnt <= mask_cnt - 1'b1;
      end else if (owner_vld != ser_vld_out) begin
         err_align <= 1'b1;
      end
   end

endmodule

// File: tb/tb_serial_feed_sched.sv
// Directed bench for serial_feed_sched with a small behavioural serializer driving ser_vld_out.
module tb_serial_feed_sched;

   localparam int BW      = 16;
   localparam int CYCS    = 4;
   localparam int VEC_LEN = 27;
   localparam int NUM_REQ = 4;
   localparam int IDW     = 2;
   localparam int VW      = VEC_LEN * BW;

   logic                     clock;
   logic                     reset_n;
   logic [NUM_REQ-1:0]       req_vld;
   logic [NUM_REQ*VW-1:0]    req_data;
   logic [NUM_REQ-1:0]       req_rdy;
   logic                     ser_vld_in;
   logic [VW-1:0]            ser_in;
   logic                     ser_vld_out;
   logic [IDW-1:0]           owner_id;
   logic                     owner_vld;
   logic                     err_align;

   logic [VW-1:0]            vec_mem [NUM_REQ];
   logic [2:0]               ser_cnt = '0;
   logic                     force_low;
   logic [IDW-1:0]           exp_q[$];
   int                       total;
   int                       passed;

   serial_feed_sched #(
      .BW(BW), .CYCS(CYCS), .VEC_LEN(VEC_LEN), .NUM_REQ(NUM_REQ)
   ) dut (
      .clock(clock), .reset_n(reset_n), .req_vld(req_vld), .req_data(req_data),
      .req_rdy(req_rdy), .ser_vld_in(ser_vld_in), .ser_in(ser_in),
      .ser_vld_out(ser_vld_out), .owner_id(owner_id), .owner_vld(owner_vld),
      .err_align(err_align)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
      assign req_data[g*VW +: VW] = vec_mem[g];
   end

   // Serializer stand-in: emits CYCS chunks after each load, never reset.
   always @(posedge clock) begin
      if (ser_vld_in) ser_cnt <= 3'(CYCS);
      else if (ser_cnt != 0) ser_cnt <= ser_cnt - 3'd1;
   end
   assign ser_vld_out = (ser_cnt != 0) && !force_low;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic mid();
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      req_vld = '0;
      idle(2);
      reset_n = 1'b1;
      idle(6);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      req_vld = 4'b1111;
      mid();
      total++; if (req_rdy !== 4'b0000) $display("FAIL reset_rdy got %b want 0000", req_rdy); else passed++;
      total++; if (ser_vld_in !== 1'b0) $display("FAIL reset_ser_vld_in got %b want 0", ser_vld_in); else passed++;
      total++; if (ser_in !== '0) $display("FAIL reset_ser_in got %h want 0", ser_in); else passed++;
      total++; if (owner_id !== 2'd0 || owner_vld !== 1'b0) $display("FAIL reset_owner got %0d/%b want 0/0", owner_id, owner_vld); else passed++;
      total++; if (err_align !== 1'b0) $display("FAIL reset_err got %b want 0", err_align); else passed++;
      step();
      reset_n = 1'b1;
      req_vld = '0;
      idle(6);
   endtask

   task automatic test_single();
      req_vld = 4'b0010;
      mid();
      total++; if (req_rdy !== 4'b0010) $display("FAIL single_rdy got %b want 0010", req_rdy); else passed++;
      step();
      req_vld = '0;
      mid();
      total++; if (ser_vld_in !== 1'b1) $display("FAIL single_ser_vld_in got %b want 1", ser_vld_in); else passed++;
      total++; if (ser_in[15:0] !== 16'hA5C3 || ser_in !== vec_mem[1]) $display("FAIL single_ser_in got %h want %h", ser_in[15:0], 16'hA5C3); else passed++;
      total++; if (owner_vld !== 1'b0) $display("FAIL single_owner_early got %b want 0", owner_vld); else passed++;
      for (int c = 2; c <= 6; c++) begin
         step();
         mid();
         total++;
         if (owner_vld !== (c <= 5) || (c <= 5 && owner_id !== 2'd1))
            $display("FAIL single_owner c%0d got %b/%0d want %b/1", c, owner_vld, owner_id, (c <= 5));
         else passed++;
      end
      total++; if (err_align !== 1'b0) $display("FAIL single_err got %b want 0", err_align); else passed++;
      idle(3);
   endtask

   task automatic test_back_to_back();
      logic [IDW-1:0] g;
      logic [IDW-1:0] got;
      apply_reset();
      for (int c = 0; c <= 23; c++) begin
         req_vld = (c <= 16) ? 4'b1111 : 4'b0000;
`ifdef SERIAL_FEED_SCHED_RR_EN
         g = IDW'((c / 4) % NUM_REQ);
`else
         g = '0;
`endif
         mid();
         if (c <= 16) begin
            total++;
            if (c % 4 == 0) begin
               if (req_rdy !== (4'b0001 << g)) $display("FAIL b2b_rdy c%0d got %b want %b", c, req_rdy, 4'b0001 << g);
               else passed++;
               exp_q.push_back(g);
            end else begin
               if (req_rdy !== 4'b0000) $display("FAIL b2b_rdy_busy c%0d got %b want 0000", c, req_rdy);
               else passed++;
            end
         end
         if (c % 4 == 1 && c <= 17) begin
            total++;
            if (ser_vld_in !== 1'b1 || ser_in !== vec_mem[g]) $display("FAIL b2b_load c%0d got %b want 1", c, ser_vld_in);
            else passed++;
         end
         total++;
         if (owner_vld !== (c >= 2 && c <= 21)) $display("FAIL b2b_owner_vld c%0d got %b want %b", c, owner_vld, (c >= 2 && c <= 21));
         else passed++;
         if (c >= 2 && c <= 21 && (c - 2) % 4 == 0) begin
            got = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            total++;
            if (owner_id !== got) $display("FAIL b2b_owner_id c%0d got %0d want %0d", c, owner_id, got);
            else passed++;
         end
         step();
      end
      total++; if (err_align !== 1'b0) $display("FAIL b2b_err got %b want 0", err_align); else passed++;
      idle(2);
   endtask

   task automatic test_mid_slot();
      req_vld = 4'b0001;
      mid();
      step();
      req_vld = 4'b0000;
      step();
      req_vld = 4'b0100;
      mid();
      total++; if (req_rdy !== 4'b0000) $display("FAIL midslot_c2 got %b want 0000", req_rdy); else passed++;
      step();
      mid();
      total++; if (req_rdy !== 4'b0000) $display("FAIL midslot_c3 got %b want 0000", req_rdy); else passed++;
      step();
      mid();
      total++; if (req_rdy !== 4'b0100) $display("FAIL midslot_c4 got %b want 0100", req_rdy); else passed++;
      step();
      req_vld = 4'b0000;
      mid();
      total++; if (owner_id !== 2'd0 || owner_vld !== 1'b1) $display("FAIL midslot_c5 got %0d/%b want 0/1", owner_id, owner_vld); else passed++;
      step();
      mid();
      total++; if (owner_id !== 2'd2 || owner_vld !== 1'b1) $display("FAIL midslot_c6 got %0d/%b want 2/1", owner_id, owner_vld); else passed++;
      idle(6);
   endtask

   task automatic test_align_err();
      total++; if (err_align !== 1'b0) $display("FAIL align_pre got %b want 0", err_align); else passed++;
      req_vld = 4'b0001;
      step();
      req_vld = 4'b0000;
      step();
      step();
      force_low = 1'b1;
      mid();
      total++; if (err_align !== 1'b0) $display("FAIL align_c3 got %b want 0", err_align); else passed++;
      step();
      force_low = 1'b0;
      mid();
      total++; if (err_align !== 1'b1) $display("FAIL align_c4 got %b want 1", err_align); else passed++;
      idle(4);
      mid();
      total++; if (err_align !== 1'b1) $display("FAIL align_sticky got %b want 1", err_align); else passed++;
      idle(3);
   endtask

   task automatic test_reset_mid();
      req_vld = 4'b1000;
      step();
      req_vld = 4'b0000;
      step();
      mid();
      total++; if (err_align !== 1'b1 || owner_id !== 2'd3) $display("FAIL rstmid_pre got %b/%0d want 1/3", err_align, owner_id); else passed++;
      step();
      reset_n = 1'b0;
      req_vld = 4'b0100;
      #1;
      total++;
      if (owner_vld !== 1'b0 || owner_id !== 2'd0 || err_align !== 1'b0 || ser_vld_in !== 1'b0 || ser_in !== '0 || req_rdy !== 4'b0000)
         $display("FAIL rstmid_async got %b/%0d/%b/%b want 0/0/0/0", owner_vld, owner_id, err_align, ser_vld_in);
      else passed++;
      #1;
      reset_n = 1'b1;
      mid();
      total++; if (req_rdy !== 4'b0100) $display("FAIL rstmid_grant got %b want 0100", req_rdy); else passed++;
      step();
      req_vld = 4'b0000;
      mid();
      total++; if (ser_vld_in !== 1'b1 || ser_in !== vec_mem[2]) $display("FAIL rstmid_load got %b want 1", ser_vld_in); else passed++;
      step();
      mid();
      total++; if (owner_vld !== 1'b1 || owner_id !== 2'd2) $display("FAIL rstmid_owner got %b/%0d want 1/2", owner_vld, owner_id); else passed++;
      for (int c = 6; c <= 11; c++) begin
         step();
         mid();
         total++;
         if (err_align !== 1'b0) $display("FAIL rstmid_err c%0d got %b want 0", c, err_align);
         else passed++;
      end
   endtask

   initial begin
      total     = 0;
      passed    = 0;
      force_low = 1'b0;
      reset_n   = 1'b0;
      req_vld   = '0;
      for (int i = 0; i < NUM_REQ; i++)
         for (int k = 0; k < VEC_LEN; k++)
            vec_mem[i][k*BW +: BW] = 16'((i + 1) * 16'h1111) ^ 16'(k * 16'h0101);
      vec_mem[1][15:0] = 16'hA5C3;
      test_reset();
      test_single();
      test_back_to_back();
      test_mid_slot();
      test_align_err();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
